// File: rtl/mii_pkg.sv
// Shared MII code constants, scheduler state encoding and the terminate-word builder
// used by the transmit scheduler.
package mii_pkg;

  localparam logic [7:0] MII_IDLE     = 8'h07;
  localparam logic [7:0] MII_START    = 8'hFB;
  localparam logic [7:0] MII_TERM     = 8'hFD;
  localparam logic [7:0] MII_ERROR    = 8'hFE;
  localparam logic [7:0] MII_PREAMBLE = 8'h55;
  localparam logic [7:0] MII_SFD      = 8'hD5;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TERM, S_IPG} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } mii_word_t;

  localparam mii_word_t IDLE_WORD  = '{data: {8{MII_IDLE}}, ctrl: 8'hFF};
  localparam mii_word_t START_WORD = '{data: {MII_SFD, {6{MII_PREAMBLE}}, MII_START}, ctrl: 8'h01};
  localparam mii_word_t ERROR_WORD = '{data: {8{MII_ERROR}}, ctrl: 8'hFF};

  // nbytes = 0 yields the standalone terminate word (FD in lane 0).
  function automatic mii_word_t term_word(input logic [63:0] payload, input logic [2:0] nbytes);
    mii_word_t w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(nbytes)) begin
        w.data[k*8 +: 8] = payload[k*8 +: 8];
        w.ctrl[k]        = 1'b0;
      end else if (k == int'(nbytes)) begin
        w.data[k*8 +: 8] = MII_TERM;
        w.ctrl[k]        = 1'b1;
      end else begin
        w.data[k*8 +: 8] = MII_IDLE;
        w.ctrl[k]        = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mii_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the registered pointer,
// moving the pointer to the winner when advance is strobed.
module mii_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] ptr
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] sel;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    sel   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        sel        = PW'(idx);
      end
    end
  end

  // Reset value NUM_REQ-1 makes source 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NUM_REQ - 1);
    end else if (advance && found) begin
      ptr <= sel;
    end
  end

endmodule

// File: rtl/mii_tx_scheduler.sv
// Round-robin 64-bit MII transmit scheduler: frames source payload with start,
// terminate and inter-packet-gap words. Define MII_TX_STATS_EN for frame/byte/error counters.
module mii_tx_scheduler
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2,
  parameter int IPG_WORDS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*3-1:0]          req_bytes,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         mii_data,
  output logic [7:0]                    mii_ctrl,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          underrun
`ifdef MII_TX_STATS_EN
  ,
  output logic [31:0]                   frame_count,
  output logic [31:0]                   byte_count,
  output logic [15:0]                   err_count
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  state_t             state, state_d;
  logic [3:0]         ipg_cnt, ipg_cnt_d;
  logic [NUM_REQ-1:0] arb_grant, grant_d;
  logic [PW-1:0]      owner;
  logic               advance, busy_d, underrun_d;
  logic               sel_valid, sel_last;
  logic [63:0]        sel_data;
  logic [2:0]         sel_bytes;
  mii_word_t          word_d;

  // The arbiter pointer only moves on a start decision, so it doubles as the owner index.
  mii_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (arb_grant),
    .ptr     (owner)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_bytes = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == PW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: 64];
        sel_bytes = req_bytes[i*3 +: 3];
      end
    end
  end

  assign req_ready = (state == S_PAYLOAD) ? grant : '0;

  always_comb begin
    state_d    = state;
    ipg_cnt_d  = ipg_cnt;
    word_d     = IDLE_WORD;
    busy_d     = 1'b0;
    underrun_d = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          advance = 1'b1;
          word_d  = START_WORD;
          busy_d  = 1'b1;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        busy_d = 1'b1;
        if (!sel_valid) begin
          word_d     = ERROR_WORD;
          underrun_d = 1'b1;
        end else if (!sel_last) begin
          word_d = '{data: sel_data, ctrl: 8'h00};
        end else if (sel_bytes == 3'd0) begin
          word_d  = '{data: sel_data, ctrl: 8'h00};
          state_d = S_TERM;
        end else begin
          word_d = term_word(sel_data, sel_bytes);
          if (IPG_WORDS == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_IPG;
            ipg_cnt_d = 4'(IPG_WORDS);
          end
        end
      end
      S_TERM: begin
        busy_d = 1'b1;
        word_d = term_word(64'h0, 3'd0);
        if (IPG_WORDS == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_IPG;
          ipg_cnt_d = 4'(IPG_WORDS);
        end
      end
      S_IPG: begin
        ipg_cnt_d = ipg_cnt - 4'd1;
        if (ipg_cnt <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    grant_d = advance ? arb_grant : (busy_d ? grant : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ipg_cnt  <= '0;
      mii_data <= IDLE_WORD.data;
      mii_ctrl <= IDLE_WORD.ctrl;
      grant    <= '0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_d;
      ipg_cnt  <= ipg_cnt_d;
      mii_data <= word_d.data;
      mii_ctrl <= word_d.ctrl;
      grant    <= grant_d;
      busy     <= busy_d;
      underrun <= underrun_d;
    end
  end

`ifdef MII_TX_STATS_EN
  // A terminate-carrying word is either the standalone TERM word or a short last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      byte_count  <= '0;
      err_count   <= '0;
    end else begin
      if ((state == S_TERM) ||
          (state == S_PAYLOAD && sel_valid && sel_last && sel_bytes != 3'd0)) begin
        frame_count <= frame_count + 32'd1;
      end
      if (state == S_PAYLOAD && sel_valid) begin
        if (sel_last && sel_bytes != 3'd0) begin
          byte_count <= byte_count + 32'(sel_bytes);
        end else begin
          byte_count <= byte_count + 32'd8;
        end
      end
      if (underrun_d && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Scoreboard bench for mii_tx_scheduler: stimulus pushes hand-computed expected words,
// a negedge monitor pops and compares them against the registered outputs.
module tb_mii_tx_scheduler;

  localparam int NUM_REQ = 2;
  localparam int IPG     = 2;

  localparam logic [63:0] IDLEW  = 64'h0707070707070707;
  localparam logic [63:0] STARTW = 64'hD5555555555555FB;
  localparam logic [63:0] TERMW  = 64'h07070707070707FD;
  localparam logic [63:0] ERRW   = 64'hFEFEFEFEFEFEFEFE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_REQ-1:0]  req_valid = '0;
  logic [NUM_REQ*64-1:0] req_data = '0;
  logic [NUM_REQ-1:0]  req_last = '0;
  logic [NUM_REQ*3-1:0] req_bytes = '0;
  logic [NUM_REQ-1:0]  req_ready;
  logic [63:0]         mii_data;
  logic [7:0]          mii_ctrl;
  logic [NUM_REQ-1:0]  grant;
  logic                busy;
  logic                underrun;
`ifdef MII_TX_STATS_EN
  logic [31:0]         frame_count;
  logic [31:0]         byte_count;
  logic [15:0]         err_count;
`endif

  typedef struct {
    string       nm;
    logic [63:0] d;
    logic [7:0]  c;
    logic [1:0]  g;
    logic        b;
    logic        u;
    logic [1:0]  r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mii_tx_scheduler #(.DATA_WIDTH(64), .NUM_REQ(NUM_REQ), .IPG_WORDS(IPG)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_bytes (req_bytes),
    .req_ready (req_ready),
    .mii_data  (mii_data),
    .mii_ctrl  (mii_ctrl),
    .grant     (grant),
    .busy      (busy),
    .underrun  (underrun)
`ifdef MII_TX_STATS_EN
    ,
    .frame_count (frame_count),
    .byte_count  (byte_count),
    .err_count   (err_count)
`endif
  );

  task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] l,
                               input logic [63:0] d0, input logic [2:0] b0,
                               input logic [63:0] d1, input logic [2:0] b1);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_last  = l;
    req_data  = {d1, d0};
    req_bytes = {b1, b0};
  endtask

  // Expected state of the outputs right after the coming edge; req_ready is the value
  // that the new state presents for the following cycle.
  task automatic pushExpected(input string nm, input logic [63:0] d, input logic [7:0] c,
                              input logic [1:0] g, input logic b, input logic u,
                              input logic [1:0] r);
    exp_t e;
    @(posedge clk);
    e.nm = nm; e.d = d; e.c = c; e.g = g; e.b = b; e.u = u; e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({mii_data, mii_ctrl, grant, busy, underrun, req_ready} !== {e.d, e.c, e.g, e.b, e.u, e.r}) begin
      $display("[TB] FAIL %s: got data=%h ctrl=%h grant=%b busy=%b underrun=%b ready=%b, want data=%h ctrl=%h grant=%b busy=%b underrun=%b ready=%b",
               e.nm, mii_data, mii_ctrl, grant, busy, underrun, req_ready,
               e.d, e.c, e.g, e.b, e.u, e.r);
    end else begin
      passed++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic ipgWords(input string nm);
    for (int i = 0; i < IPG; i++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
      pushExpected(nm, IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] a, b, c, d, p, q, e1, e2, f1, g, h1, h2, j1, j2;
    a  = 64'h0102030405060708; b  = 64'h1112131415161718; c  = 64'h2122232425262728;
    d  = 64'h1122334455667788; p  = 64'hA0A1A2A3A4A5A6A7; q  = 64'hB0B1B2B3B4B5B6B7;
    e1 = 64'hE1E1E1E1E1E1E1E1; e2 = 64'hE2E2E2E2E2E2E2E2; f1 = 64'hF1F1F1F1F1F1F1F1;
    g  = 64'h00000000000000C3; h1 = 64'hCAFEF00DDEADBEEF; h2 = 64'h0123456789ABCDEF;
    j1 = 64'h5A5A5A5A5A5A5A5A; j2 = 64'hA5A5A5A5A5A5A5A5;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
      pushExpected("reset", IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);
    end

    // Source 0: three full words, last one with bytes=0 needs a separate TERM word.
    applyStimulus(1'b0, 2'b01, 2'b00, a, 3'd0, 64'h0, 3'd0);
    pushExpected("t1_start", STARTW, 8'h01, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b00, a, 3'd0, 64'h0, 3'd0);
    pushExpected("t1_A", a, 8'h00, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b00, b, 3'd0, 64'h0, 3'd0);
    pushExpected("t1_B", b, 8'h00, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b01, c, 3'd0, 64'h0, 3'd0);
    pushExpected("t1_C", c, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
    pushExpected("t1_term", TERMW, 8'hFF, 2'b01, 1'b1, 1'b0, 2'b00);
    ipgWords("t1_ipg");
    applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
    pushExpected("t1_idle", IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);

    // Source 1: single short last word of 3 bytes.
    applyStimulus(1'b0, 2'b10, 2'b10, 64'h0, 3'd0, d, 3'd3);
    pushExpected("t2_start", STARTW, 8'h01, 2'b10, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b0, 2'b10, 2'b10, 64'h0, 3'd0, d, 3'd3);
    pushExpected("t2_last", 64'h07070707FD667788, 8'hF8, 2'b10, 1'b1, 1'b0, 2'b00);
    ipgWords("t2_ipg");

    // Both sources valid continuously: grants alternate, IPG idle words between frames.
    for (int f = 0; f < 2; f++) begin
      applyStimulus(1'b0, 2'b11, 2'b11, p, 3'd2, q, 3'd6);
      pushExpected("t3_start0", STARTW, 8'h01, 2'b01, 1'b1, 1'b0, 2'b01);
      applyStimulus(1'b0, 2'b11, 2'b11, p, 3'd2, q, 3'd6);
      pushExpected("t3_last0", 64'h0707070707FDA6A7, 8'hFC, 2'b01, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < IPG; i++) begin
        applyStimulus(1'b0, 2'b11, 2'b11, p, 3'd2, q, 3'd6);
        pushExpected("t3_ipg0", IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);
      end
      applyStimulus(1'b0, 2'b11, 2'b11, p, 3'd2, q, 3'd6);
      pushExpected("t3_start1", STARTW, 8'h01, 2'b10, 1'b1, 1'b0, 2'b10);
      applyStimulus(1'b0, 2'b11, 2'b11, p, 3'd2, q, 3'd6);
      pushExpected("t3_last1", 64'h07FDB2B3B4B5B6B7, 8'hC0, 2'b10, 1'b1, 1'b0, 2'b00);
      for (int i = 0; i < IPG; i++) begin
        applyStimulus(1'b0, (f == 1 && i == IPG - 1) ? 2'b00 : 2'b11, 2'b11, p, 3'd2, q, 3'd6);
        pushExpected("t3_ipg1", IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);
      end
    end

    // Underrun: source 0 drops valid for two cycles while source 1 is valid.
    applyStimulus(1'b0, 2'b01, 2'b00, e1, 3'd0, 64'h0, 3'd0);
    pushExpected("t4_start", STARTW, 8'h01, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b00, e1, 3'd0, 64'h0, 3'd0);
    pushExpected("t4_E1", e1, 8'h00, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b10, 2'b00, 64'h0, 3'd0, q, 3'd0);
    pushExpected("t4_err0", ERRW, 8'hFF, 2'b01, 1'b1, 1'b1, 2'b01);
    applyStimulus(1'b0, 2'b10, 2'b00, 64'h0, 3'd0, q, 3'd0);
    pushExpected("t4_err1", ERRW, 8'hFF, 2'b01, 1'b1, 1'b1, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b01, e2, 3'd0, 64'h0, 3'd0);
    pushExpected("t4_E2", e2, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
    pushExpected("t4_term", TERMW, 8'hFF, 2'b01, 1'b1, 1'b0, 2'b00);
    ipgWords("t4_ipg");

    // Reset mid-frame: idle next, pointer back to NUM_REQ-1 so source 0 wins a tie.
    applyStimulus(1'b0, 2'b01, 2'b00, f1, 3'd0, 64'h0, 3'd0);
    pushExpected("t5_start", STARTW, 8'h01, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b00, f1, 3'd0, 64'h0, 3'd0);
    pushExpected("t5_F1", f1, 8'h00, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b1, 2'b01, 2'b00, f1, 3'd0, 64'h0, 3'd0);
    pushExpected("t5_reset", IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b01, g, 3'd1, j1, 3'd0);
    pushExpected("t5_restart", STARTW, 8'h01, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b11, 2'b01, g, 3'd1, j1, 3'd0);
    pushExpected("t5_last", 64'h070707070707FDC3, 8'hFE, 2'b01, 1'b1, 1'b0, 2'b00);
    ipgWords("t5_ipg");

    // Fresh reset, then frames of 11 and 16 bytes.
    applyStimulus(1'b1, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
    pushExpected("t6_reset", IDLEW, 8'hFF, 2'b00, 1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, h1, 3'd0, 64'h0, 3'd0);
    pushExpected("t6_startA", STARTW, 8'h01, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b00, h1, 3'd0, 64'h0, 3'd0);
    pushExpected("t6_H1", h1, 8'h00, 2'b01, 1'b1, 1'b0, 2'b01);
    applyStimulus(1'b0, 2'b01, 2'b01, h2, 3'd3, 64'h0, 3'd0);
    pushExpected("t6_H2", 64'h07070707FDABCDEF, 8'hF8, 2'b01, 1'b1, 1'b0, 2'b00);
    ipgWords("t6_ipgA");
    applyStimulus(1'b0, 2'b10, 2'b00, 64'h0, 3'd0, j1, 3'd0);
    pushExpected("t6_startB", STARTW, 8'h01, 2'b10, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b0, 2'b10, 2'b00, 64'h0, 3'd0, j1, 3'd0);
    pushExpected("t6_J1", j1, 8'h00, 2'b10, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b0, 2'b10, 2'b10, 64'h0, 3'd0, j2, 3'd0);
    pushExpected("t6_J2", j2, 8'h00, 2'b10, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 64'h0, 3'd0, 64'h0, 3'd0);
    pushExpected("t6_term", TERMW, 8'hFF, 2'b10, 1'b1, 1'b0, 2'b00);
    ipgWords("t6_ipgB");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end else begin
      passed++;
    end

`ifdef MII_TX_STATS_EN
    checks++;
    if (frame_count !== 32'd2) $display("[TB] FAIL frame_count: got %0d, want 2", frame_count);
    else passed++;
    checks++;
    if (byte_count !== 32'd27) $display("[TB] FAIL byte_count: got %0d, want 27", byte_count);
    else passed++;
    checks++;
    if (err_count !== 16'd0) $display("[TB] FAIL err_count: got %0d, want 0", err_count);
    else passed++;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
